// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline, with the MEM/WB register.
// Issues byte/halfword/word loads and stores to a data memory whose ack can
// take a variable number of cycles. Load data is formatted and registered
// together with everything the write-back stage consumes.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ex_*                EX/MEM results: alu_result (address or value),
//                       store_data, rd, wb {we, mem_sel}, mem_read,
//                       mem_write, size, sign_ext, nop
//   dmem_*              data memory interface: req/we/addr/be/wdata out,
//                       rdata/ack in
//   datafrommem, datafromimm, wb, nop_mem, wr_reg   MEM/WB register outputs
//   stall_mem           holds the upstream stages while an access is pending
//   align_err           one-cycle pulse for a misaligned access
module mem_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic [1:0]        ex_wb,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_sign_ext,
  input  logic              ex_nop,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [31:0]       datafrommem,
  output logic [31:0]       datafromimm,
  output logic [1:0]        wb,
  output logic              nop_mem,
  output logic [4:0]        wr_reg,
  output logic              stall_mem,
  output logic              align_err
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e state_q, state_d;

  // captured access while waiting for ack
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       res_q, res_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [4:0]        rd_q, rd_d;
  logic [1:0]        wbc_q, wbc_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;

  // MEM/WB register
  logic [31:0] dfm_q, dfm_d;
  logic [31:0] dfi_q, dfi_d;
  logic [1:0]  wb_q, wb_d;
  logic        nop_q, nop_d;
  logic [4:0]  wr_q, wr_d;
  logic        aerr_q, aerr_d;

  logic        access, misalign;
  logic [3:0]  ex_be;
  logic [31:0] ex_wdata;
  logic [1:0]  sel_lo, sel_size;
  logic        sel_sext;
  logic [31:0] load_data;

  function automatic logic [3:0] fmt_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   fmt_be = 4'b0001 << a;
      2'b01:   fmt_be = a[1] ? 4'b1100 : 4'b0011;
      default: fmt_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] fmt_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   fmt_wdata = {4{d[7:0]}};
      2'b01:   fmt_wdata = {2{d[15:0]}};
      default: fmt_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] r, input logic [1:0] sz,
                                           input logic [1:0] a, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = r[7:0];
      2'd1:    b = r[15:8];
      2'd2:    b = r[23:16];
      default: b = r[31:24];
    endcase
    h = a[1] ? r[31:16] : r[15:0];
    case (sz)
      2'b00:   fmt_load = {{24{sx & b[7]}}, b};
      2'b01:   fmt_load = {{16{sx & h[15]}}, h};
      default: fmt_load = r;
    endcase
  endfunction

  always_comb begin
    access   = ~ex_nop & (ex_mem_read | ex_mem_write);
    misalign = ((ex_size == 2'b01) & ex_alu_result[0]) |
               (ex_size[1] & (ex_alu_result[1:0] != 2'b00));
    ex_be    = fmt_be(ex_size, ex_alu_result[1:0]);
    ex_wdata = fmt_wdata(ex_size, ex_store_data);
  end

  // Memory interface comes straight from EX in IDLE and from the captured
  // copy in WAIT, so it stays stable regardless of the EX inputs.
  always_comb begin
    if (state_q == ST_WAIT) begin
      dmem_req   = 1'b1;
      dmem_we    = we_q;
      dmem_addr  = addr_q;
      dmem_be    = be_q;
      dmem_wdata = wdata_q;
      sel_lo     = addr_q[1:0];
      sel_size   = size_q;
      sel_sext   = sext_q;
    end else begin
      dmem_req   = access & ~misalign;
      dmem_we    = access & ~misalign & ex_mem_write;
      dmem_addr  = ex_alu_result[ADDR_W-1:0];
      dmem_be    = ex_be;
      dmem_wdata = ex_wdata;
      sel_lo     = ex_alu_result[1:0];
      sel_size   = ex_size;
      sel_sext   = ex_sign_ext;
    end
    load_data = fmt_load(dmem_rdata, sel_size, sel_lo, sel_sext);
    stall_mem = dmem_req & ~dmem_ack;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    res_d   = res_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rd_d    = rd_q;
    wbc_d   = wbc_q;
    size_d  = size_q;
    sext_d  = sext_q;
    dfm_d   = dfm_q;
    dfi_d   = dfi_q;
    wb_d    = wb_q;
    nop_d   = nop_q;
    wr_d    = wr_q;
    aerr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!access) begin
          dfm_d = '0;
          dfi_d = ex_alu_result;
          wb_d  = ex_wb;
          wr_d  = ex_rd;
          nop_d = ex_nop;
        end else if (misalign) begin
          dfm_d  = '0;
          dfi_d  = ex_alu_result;
          wr_d   = ex_rd;
          wb_d   = '0;
          nop_d  = 1'b1;
          aerr_d = 1'b1;
        end else if (dmem_ack) begin
          dfm_d = ex_mem_write ? '0 : load_data;
          dfi_d = ex_alu_result;
          wb_d  = ex_wb;
          wr_d  = ex_rd;
          nop_d = 1'b0;
        end else begin
          addr_d  = ex_alu_result[ADDR_W-1:0];
          res_d   = ex_alu_result;
          be_d    = ex_be;
          wdata_d = ex_wdata;
          we_d    = ex_mem_write;
          rd_d    = ex_rd;
          wbc_d   = ex_wb;
          size_d  = ex_size;
          sext_d  = ex_sign_ext;
          dfm_d   = '0;
          wb_d    = '0;
          nop_d   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          dfm_d   = we_q ? '0 : load_data;
          dfi_d   = res_q;
          wb_d    = wbc_q;
          wr_d    = rd_q;
          nop_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          dfm_d = '0;
          wb_d  = '0;
          nop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      res_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      wbc_q   <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      dfm_q   <= '0;
      dfi_q   <= '0;
      wb_q    <= '0;
      nop_q   <= 1'b1;
      wr_q    <= '0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      res_q   <= res_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wbc_q   <= wbc_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      dfm_q   <= dfm_d;
      dfi_q   <= dfi_d;
      wb_q    <= wb_d;
      nop_q   <= nop_d;
      wr_q    <= wr_d;
      aerr_q  <= aerr_d;
    end
  end

  assign datafrommem = dfm_q;
  assign datafromimm = dfi_q;
  assign wb          = wb_q;
  assign nop_mem     = nop_q;
  assign wr_reg      = wr_q;
  assign align_err   = aerr_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage. Inputs change 1ns
// after the rising edge; combinational outputs are checked 1ns later and
// registered outputs 1ns after the next rising edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ex_alu_result, ex_store_data, dmem_rdata;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb, ex_size;
  logic        ex_mem_read, ex_mem_write, ex_sign_ext, ex_nop, dmem_ack;
  logic        dmem_req, dmem_we, nop_mem, stall_mem, align_err;
  logic [31:0] dmem_addr, dmem_wdata, datafrommem, datafromimm;
  logic [3:0]  dmem_be;
  logic [1:0]  wb;
  logic [4:0]  wr_reg;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned stalls;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_wb(ex_wb), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_size(ex_size), .ex_sign_ext(ex_sign_ext),
    .ex_nop(ex_nop),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .datafrommem(datafrommem), .datafromimm(datafromimm), .wb(wb),
    .nop_mem(nop_mem), .wr_reg(wr_reg), .stall_mem(stall_mem),
    .align_err(align_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic set_ex(input logic nop, input logic rd_en, input logic wr_en,
                        input logic [31:0] alu, input logic [31:0] sd,
                        input logic [1:0] sz, input logic sx,
                        input logic [4:0] rd, input logic [1:0] w);
    ex_nop = nop; ex_mem_read = rd_en; ex_mem_write = wr_en;
    ex_alu_result = alu; ex_store_data = sd; ex_size = sz;
    ex_sign_ext = sx; ex_rd = rd; ex_wb = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    set_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 5'd0, 2'b00);
    step();
    step();
    check("rst_nop", nop_mem, 1);
    check("rst_wb", wb, 0);
    check("rst_dfm", datafrommem, 0);
    check("rst_dfi", datafromimm, 0);
    check("rst_wr", wr_reg, 0);
    check("rst_aerr", align_err, 0);
    reset = 1'b0;
    #1;
    check("idle_req", dmem_req, 0);
    check("idle_stall", stall_mem, 0);
    step();

    // lw 0x100, immediate ack
    set_ex(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 5'd5, 2'b11);
    dmem_rdata = 32'hDEADBEEF; dmem_ack = 1'b1;
    #1;
    check("lw_req", dmem_req, 1);
    check("lw_we", dmem_we, 0);
    check("lw_addr", dmem_addr, 32'h100);
    check("lw_be", dmem_be, 4'hF);
    check("lw_stall", stall_mem, 0);
    step();
    check("lw_dfm", datafrommem, 32'hDEADBEEF);
    check("lw_dfi", datafromimm, 32'h100);
    check("lw_nop", nop_mem, 0);
    check("lw_wb", wb, 2'b11);
    check("lw_wr", wr_reg, 5'd5);

    // lb / lbu at 0x103, lh signed at 0x102
    set_ex(1'b0, 1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 5'd6, 2'b11);
    dmem_rdata = 32'h80123456;
    #1;
    check("lb_be", dmem_be, 4'b1000);
    step();
    check("lb_dfm", datafrommem, 32'hFFFFFF80);
    ex_sign_ext = 1'b0;
    step();
    check("lbu_dfm", datafrommem, 32'h00000080);
    set_ex(1'b0, 1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 5'd6, 2'b11);
    dmem_rdata = 32'hBEEF1234;
    step();
    check("lh_dfm", datafrommem, 32'hFFFFBEEF);
    set_ex(1'b0, 1'b1, 1'b0, 32'h101, 32'h0, 2'b00, 1'b0, 5'd6, 2'b11);
    dmem_rdata = 32'h0000A500;
    step();
    check("lbu1_dfm", datafrommem, 32'h000000A5);

    // lw 0x300 with ack after 3 stall cycles; EX inputs disturbed while waiting
    set_ex(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 5'd7, 2'b11);
    dmem_ack = 1'b0;
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall_mem) stalls++;
      check("wait_addr", dmem_addr, 32'h300);
      check("wait_req", dmem_req, 1);
      step();
      check("wait_nop", nop_mem, 1);
      check("wait_wb", wb, 0);
      ex_alu_result = 32'h999;
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #1;
    check("ack_stall", stall_mem, 0);
    check("ack_addr", dmem_addr, 32'h300);
    check("stall_cnt", stalls, 3);
    step();
    set_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 5'd0, 2'b00);
    check("dl_dfm", datafrommem, 32'hCAFEF00D);
    check("dl_dfi", datafromimm, 32'h300);
    check("dl_nop", nop_mem, 0);
    check("dl_wb", wb, 2'b11);
    check("dl_wr", wr_reg, 5'd7);
    #1;
    check("dl_idle_req", dmem_req, 0);
    step();

    // sh 0x202, sb 0x201
    set_ex(1'b0, 1'b0, 1'b1, 32'h202, 32'h1234ABCD, 2'b01, 1'b0, 5'd0, 2'b00);
    #1;
    check("sh_be", dmem_be, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hABCDABCD);
    check("sh_we", dmem_we, 1);
    check("sh_req", dmem_req, 1);
    step();
    check("sh_nop", nop_mem, 0);
    check("sh_wb", wb, 0);
    set_ex(1'b0, 1'b0, 1'b1, 32'h201, 32'hCAFE0077, 2'b00, 1'b0, 5'd0, 2'b00);
    #1;
    check("sb_be", dmem_be, 4'b0010);
    check("sb_wdata", dmem_wdata, 32'h77777777);
    step();

    // misaligned lw 0x101
    set_ex(1'b0, 1'b1, 1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 5'd8, 2'b11);
    #1;
    check("mis_req", dmem_req, 0);
    check("mis_stall", stall_mem, 0);
    step();
    check("mis_aerr", align_err, 1);
    check("mis_nop", nop_mem, 1);
    check("mis_wb", wb, 0);
    set_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 5'd0, 2'b00);
    step();
    check("mis_aerr_pulse", align_err, 0);

    // reset while waiting, then an ALU op passes straight through
    dmem_ack = 1'b0;
    set_ex(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 5'd3, 2'b11);
    step();
    check("rw_stall", stall_mem, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 2'b10, 1'b0, 5'd9, 2'b10);
    #1;
    check("rw_req", dmem_req, 0);
    check("rw_nop", nop_mem, 1);
    check("rw_stall2", stall_mem, 0);
    step();
    check("alu_dfi", datafromimm, 32'h55);
    check("alu_dfm", datafrommem, 0);
    check("alu_nop", nop_mem, 0);
    check("alu_wb", wb, 2'b10);
    check("alu_wr", wr_reg, 5'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
